// File: rtl/crc_packet_uart_tx.sv
// crc_packet_uart_tx: byte stream -> FIFO -> UART transmitter.
// Bytes arrive on a valid/ready handshake. When a byte is flagged as the last
// of a packet, a CRC-8 byte (poly 0x07, init 0, MSB first) is queued after it.
// Every FIFO entry goes out as one UART frame: a start bit, 8 data bits LSB
// first, an optional parity bit and 1 or 2 stop bits.
module crc_packet_uart_tx #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 1160,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CRC_EN       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [7:0]               crc_out,
  output logic [7:0]               last_byte
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_NEAR  = CNTW'(DEPTH - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic            ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic {ACCEPT, PUSH_CRC} in_state_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  // One byte of CRC-8 (poly 0x07), MSB first, no reflection.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int k = 0; k < 8; k++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  in_state_t       in_state;
  tx_state_t       tx_state;
  logic [7:0]      crc_run;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      rd_data, push_data;
  logic            wr_data, wr_crc, push, pop;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            bit_end, stop_done;

  // Input side: accept only in ACCEPT with room; the CRC slot takes priority
  // over new data until it has been written.
  assign in_ready  = (in_state == ACCEPT) && !fifo_full;
  assign wr_data   = in_valid && in_ready;
  assign wr_crc    = (in_state == PUSH_CRC) && !fifo_full;
  assign push      = wr_data || wr_crc;
  assign push_data = (in_state == PUSH_CRC) ? crc_run : in_data;

  // Show-ahead read: head entry is always visible to the transmitter.
  assign rd_data = mem[rd_ptr];

  // The transmitter pops when idle or on the very last stop-bit cycle, so
  // consecutive frames abut with no idle gap.
  assign bit_end   = (baud_cnt == BAUD_MAX);
  assign stop_done = (tx_state == STOP) && bit_end && (bit_idx == LAST_STOP);
  assign pop       = !fifo_empty && ((tx_state == IDLE) || stop_done);

  assign busy = (tx_state != IDLE) || !fifo_empty || (in_state == PUSH_CRC);

  // Input FSM: running CRC per packet, then queue the CRC byte after in_last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_state <= ACCEPT;
      crc_run  <= '0;
      crc_out  <= '0;
    end else begin
      case (in_state)
        ACCEPT: begin
          if (wr_data) begin
            crc_run <= crc8_next(crc_run, in_data);
            if (in_last && (CRC_EN != 0)) in_state <= PUSH_CRC;
          end
        end
        PUSH_CRC: begin
          if (!fifo_full) begin
            crc_out  <= crc_run;
            crc_run  <= '0;
            in_state <= ACCEPT;
          end
        end
        default: in_state <= ACCEPT;
      endcase
    end
  end

  // FIFO storage; contents need no reset because count/empty gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          fifo_count <= fifo_count + 1'b1;
          fifo_empty <= 1'b0;
          fifo_full  <= (fifo_count == CNT_NEAR);
        end
        2'b01: begin
          fifo_count <= fifo_count - 1'b1;
          fifo_full  <= 1'b0;
          fifo_empty <= (fifo_count == CNTW'(1));
        end
        default: ;
      endcase
    end
  end

  // TX FSM: each bit is held for CLKS_PER_BIT cycles; tx is registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state  <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      last_byte <= '0;
    end else if (pop) begin
      tx_state  <= START;
      tx        <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= rd_data;
      last_byte <= rd_data;
      par_bit   <= (^rd_data) ^ ODD_PAR;
    end else if (tx_state != IDLE) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (tx_state)
          START: begin
            tx_state <= DATA;
            tx       <= shreg[0];
            bit_idx  <= '0;
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_MODE != 0) begin
                tx_state <= PARITY;
                tx       <= par_bit;
              end else begin
                tx_state <= STOP;
                tx       <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
          PARITY: begin
            tx_state <= STOP;
            tx       <= 1'b1;
          end
          STOP: begin
            if (bit_idx == LAST_STOP) begin
              tx_state <= IDLE;
              tx       <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          default: begin
            tx_state <= IDLE;
            tx       <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc_packet_uart_tx.sv
// Directed bench for crc_packet_uart_tx. Four instances cover the parameter
// sets: u0 CRC framing, u1 even parity, u2 odd parity, u3 DEPTH=4 / 2 stop bits.
// Frame expectations are written as bit strings in line order, 4 cycles per bit.
module tb_crc_packet_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]      in_valid, in_last;
  logic [3:0][7:0] in_data;
  wire  [3:0]      in_ready, tx, busy, fifo_full, fifo_empty;
  wire  [3:0][7:0] crc_out, last_byte;
  wire  [4:0]      fc0, fc1, fc2;
  wire  [2:0]      fc3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc_packet_uart_tx #(.DEPTH(16), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .CRC_EN(1)) u0 (
    .clk(clk), .reset(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_count(fc0), .fifo_full(fifo_full[0]),
    .fifo_empty(fifo_empty[0]), .crc_out(crc_out[0]), .last_byte(last_byte[0]));

  crc_packet_uart_tx #(.DEPTH(16), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .CRC_EN(0)) u1 (
    .clk(clk), .reset(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .fifo_count(fc1), .fifo_full(fifo_full[1]),
    .fifo_empty(fifo_empty[1]), .crc_out(crc_out[1]), .last_byte(last_byte[1]));

  crc_packet_uart_tx #(.DEPTH(16), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .CRC_EN(0)) u2 (
    .clk(clk), .reset(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_last(in_last[2]),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .fifo_count(fc2), .fifo_full(fifo_full[2]),
    .fifo_empty(fifo_empty[2]), .crc_out(crc_out[2]), .last_byte(last_byte[2]));

  crc_packet_uart_tx #(.DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .CRC_EN(0)) u3 (
    .clk(clk), .reset(rst_n), .in_data(in_data[3]), .in_valid(in_valid[3]), .in_last(in_last[3]),
    .in_ready(in_ready[3]), .tx(tx[3]), .busy(busy[3]), .fifo_count(fc3), .fifo_full(fifo_full[3]),
    .fifo_empty(fifo_empty[3]), .crc_out(crc_out[3]), .last_byte(last_byte[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit string in line order -> per-cycle waveform, 4 cycles per bit.
  function automatic logic [63:0] expand(input string s);
    logic [63:0] w;
    w = '0;
    for (int c = 0; c < s.len() * 4; c++) w[c] = (s[c / 4] == "1");
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the handshake completes.
  task automatic push(input int i, input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_last[i]  = last;
    while (!in_ready[i] && n < 400) begin
      step();
      n++;
    end
    if (!in_ready[i]) chk("push_timeout", {63'd0, in_ready[i]}, 64'd1);
    else step();
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
  endtask

  // Advance until tx is low; cyc = cycles waited.
  task automatic wait_start(input int i, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (tx[i] !== 1'b0 && cyc < 400);
  endtask

  // Record the current cycle plus the next nbits*4-1 cycles of tx.
  task automatic capture(input int i, input int nbits, output logic [63:0] w);
    w = '0;
    w[0] = tx[i];
    for (int c = 1; c < nbits * 4; c++) begin
      step();
      w[c] = tx[i];
    end
  endtask

  initial begin
    int cyc;
    int n;
    int t;
    int acc[6];
    logic [63:0] w;

    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a frame with a CRC already produced.
    push(0, 8'h11, 1'b1);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    chk("rst_tx",        {63'd0, tx[0]},         64'd1);
    chk("rst_in_ready",  {63'd0, in_ready[0]},   64'd1);
    chk("rst_count",     {59'd0, fc0},           64'd0);
    chk("rst_empty",     {63'd0, fifo_empty[0]}, 64'd1);
    chk("rst_full",      {63'd0, fifo_full[0]},  64'd0);
    chk("rst_crc_out",   {56'd0, crc_out[0]},    64'd0);
    chk("rst_last_byte", {56'd0, last_byte[0]},  64'd0);
    chk("rst_busy",      {63'd0, busy[0]},       64'd0);
    repeat (2) step();
    chk("rst_tx_hold",   {63'd0, tx[0]},         64'd1);
    rst_n = 1'b1;
    step();

    // 0xA5 + CRC 0x72, back to back, start bit one edge after the write.
    push(0, 8'hA5, 1'b1);
    wait_start(0, cyc);
    chk("a5_latency", cyc, 1);
    capture(0, 10, w);
    chk("a5_frame", w, expand("0101001011"));
    step();
    capture(0, 10, w);
    chk("crc72_frame", w, expand("0010011101"));
    chk("crc_out_72",  {56'd0, crc_out[0]},   64'h72);
    chk("last_byte_72", {56'd0, last_byte[0]}, 64'h72);
    step();
    chk("a5_idle_busy", {63'd0, busy[0]}, 64'd0);
    chk("a5_idle_tx",   {63'd0, tx[0]},   64'd1);

    // Even / odd parity on 0x03, in_last ignored without CRC.
    push(1, 8'h03, 1'b1);
    wait_start(1, cyc);
    capture(1, 11, w);
    chk("even_frame", w, expand("01100000001"));
    step();
    chk("even_no_crc_busy", {63'd0, busy[1]}, 64'd0);
    chk("even_crc_out",     {56'd0, crc_out[1]}, 64'd0);
    push(2, 8'h03, 1'b1);
    wait_start(2, cyc);
    capture(2, 11, w);
    chk("odd_frame", w, expand("01100000011"));
    step();
    chk("odd_no_crc_busy", {63'd0, busy[2]}, 64'd0);

    // DEPTH=4 fill: six bytes offered back to back.
    t = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid[3] = 1'b1;
      in_data[3]  = 8'h10 + 8'(k);
      n = 0;
      while (!in_ready[3] && n < 400) begin
        step();
        t++;
        n++;
      end
      if (!in_ready[3]) chk("fill_timeout", {63'd0, in_ready[3]}, 64'd1);
      acc[k] = t;
      if (k == 5) begin
        chk("pop1_last_byte", {56'd0, last_byte[3]}, 64'h11);
        chk("pop1_count",     {61'd0, fc3},          64'd3);
      end
      step();
      t++;
      if (k == 4) begin
        chk("fill_full",     {63'd0, fifo_full[3]}, 64'd1);
        chk("fill_count",    {61'd0, fc3},          64'd4);
        chk("fill_in_ready", {63'd0, in_ready[3]},  64'd0);
        chk("fill_last0",    {56'd0, last_byte[3]}, 64'h10);
      end
    end
    in_valid[3] = 1'b0;
    chk("fill_b1_after_b0", acc[1] - acc[0], 1);
    chk("fill_b4_consec",   acc[4] - acc[1], 3);
    chk("fill_b5_time",     acc[5] - acc[1], 45);
    n = 0;
    while (busy[3] && n < 2000) begin
      step();
      n++;
    end
    chk("fill_drained", {63'd0, busy[3]}, 64'd0);

    // Two stop bits, three queued bytes, contiguous frames.
    fork
      begin
        push(3, 8'h01, 1'b0);
        push(3, 8'h80, 1'b0);
        push(3, 8'hFF, 1'b0);
      end
      begin
        wait_start(3, cyc);
        capture(3, 11, w);
        chk("sb2_frame0", w, expand("01000000011"));
        step();
        capture(3, 11, w);
        chk("sb2_frame1", w, expand("00000000111"));
        step();
        capture(3, 11, w);
        chk("sb2_frame2", w, expand("01111111111"));
        step();
        chk("sb2_busy_end", {63'd0, busy[3]}, 64'd0);
        chk("sb2_tx_end",   {63'd0, tx[3]},   64'd1);
      end
    join

    // Reset during data bit 3 discards the packet prefix.
    push(0, 8'h5A, 1'b0);
    wait_start(0, cyc);
    repeat (17) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_tx",    {63'd0, tx[0]}, 64'd1);
    chk("mid_rst_count", {59'd0, fc0},   64'd0);
    step();
    chk("mid_rst_tx2",   {63'd0, tx[0]}, 64'd1);
    rst_n = 1'b1;
    step();
    push(0, 8'hA5, 1'b1);
    wait_start(0, cyc);
    capture(0, 10, w);
    chk("post_rst_a5", w, expand("0101001011"));
    step();
    capture(0, 10, w);
    chk("post_rst_crc_frame", w, expand("0010011101"));
    chk("post_rst_crc_out", {56'd0, crc_out[0]}, 64'h72);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
